// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/LSU memory arbiter.
// Holds the FSM encoding, requester IDs and the timeout counter sizing helper.
package mem_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  // A zero timeout still needs a legal one-bit counter vector.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-controller signals seen by the arbiter.
// slave is the arbiter's view; master is the surrounding core/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_op_r;

  logic              err;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata, mem_op_r,
    output err
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata, mem_op_r,
    input  err
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick between fetch and data requesters.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
  import mem_pkg::*;
(
  input  logic    i_if_req,
  input  logic    i_d_req,
  input  req_id_t i_last_grant,
  output req_id_t o_winner,
  output logic    o_valid
);

  always_comb begin
    o_valid  = i_if_req | i_d_req;
    o_winner = REQ_IF;
    if (i_if_req && i_d_req) begin
      o_winner = (i_last_grant == REQ_D) ? REQ_IF : REQ_D;
    end else if (i_d_req) begin
      o_winner = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported memory controller between fetch and load/store.
// One transaction at a time: latch request, wait for mem_op_r or timeout, respond.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W     = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t            r_state,      w_state;
  req_id_t           r_owner,      w_owner;
  req_id_t           r_last_grant, w_last_grant;
  logic [CNT_W-1:0]  r_cnt,        w_cnt;

  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr;
  logic              r_mem_we,     w_mem_we;
  logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata;
  logic              r_if_gnt,     w_if_gnt;
  logic              r_if_rvalid,  w_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata,   w_if_rdata;
  logic              r_d_gnt,      w_d_gnt;
  logic              r_d_rvalid,   w_d_rvalid;
  logic [DATA_W-1:0] r_d_rdata,    w_d_rdata;
  logic              r_err,        w_err;

  req_id_t           w_arb_winner;
  logic              w_arb_valid;
  logic              w_timeout;
  logic [DATA_W-1:0] w_resp_data;

  rr_arb2 u_rr_arb2 (
    .i_if_req     (bus.if_req),
    .i_d_req      (bus.d_req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_arb_winner),
    .o_valid      (w_arb_valid)
  );

  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LIMIT);
  // An aborted read returns zero rather than whatever is on mem_rdata.
  assign w_resp_data = bus.mem_op_r ? bus.mem_rdata : '0;

  always_comb begin
    w_state      = r_state;
    w_owner      = r_owner;
    w_last_grant = r_last_grant;
    w_cnt        = r_cnt;
    w_mem_addr   = r_mem_addr;
    w_mem_we     = r_mem_we;
    w_mem_wdata  = r_mem_wdata;
    w_if_gnt     = 1'b0;
    w_if_rvalid  = 1'b0;
    w_if_rdata   = r_if_rdata;
    w_d_gnt      = 1'b0;
    w_d_rvalid   = 1'b0;
    w_d_rdata    = r_d_rdata;
    w_err        = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_state = BUSY;
          w_owner = w_arb_winner;
          w_cnt   = '0;
          if (w_arb_winner == REQ_D) begin
            w_mem_addr  = bus.d_addr;
            w_mem_we    = bus.d_we;
            w_mem_wdata = bus.d_wdata;
            w_d_gnt     = 1'b1;
          end else begin
            w_mem_addr  = bus.if_addr;
            w_mem_we    = 1'b0;
            w_mem_wdata = '0;
            w_if_gnt    = 1'b1;
          end
        end
      end

      BUSY: begin
        if (bus.mem_op_r || w_timeout) begin
          w_state  = RESP;
          w_mem_we = 1'b0;
          w_err    = ~bus.mem_op_r;
          if (r_owner == REQ_IF) begin
            w_if_rvalid = 1'b1;
            w_if_rdata  = w_resp_data;
          end else begin
            w_d_rvalid = 1'b1;
            // A write acknowledge leaves the last load data in place.
            if (!r_mem_we) begin
              w_d_rdata = w_resp_data;
            end
          end
        end else if (TIMEOUT != 0) begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      RESP: begin
        w_state      = IDLE;
        w_last_grant = r_owner;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= REQ_IF;
      r_last_grant <= REQ_D;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_if_gnt     <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_d_gnt      <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_d_rdata    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_owner      <= w_owner;
      r_last_grant <= w_last_grant;
      r_cnt        <= w_cnt;
      r_mem_addr   <= w_mem_addr;
      r_mem_we     <= w_mem_we;
      r_mem_wdata  <= w_mem_wdata;
      r_if_gnt     <= w_if_gnt;
      r_if_rvalid  <= w_if_rvalid;
      r_if_rdata   <= w_if_rdata;
      r_d_gnt      <= w_d_gnt;
      r_d_rvalid   <= w_d_rvalid;
      r_d_rdata    <= w_d_rdata;
      r_err        <= w_err;
    end
  end

  assign bus.if_gnt    = r_if_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_gnt     = r_d_gnt;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// cycle-schedule reference model with its own memory image.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic any_out();
    return |{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid,
             bus.d_rdata, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.err};
  endfunction

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_op_r = 0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (any_out() !== 1'b0) begin n_fail++; $display("FAIL reset_outs: got %b want 0", any_out()); end
    do_reset();
    @(negedge clk);
    n_cmp++; if (any_out() !== 1'b0) begin n_fail++; $display("FAIL post_reset_outs: got %b want 0", any_out()); end
  endtask

  task automatic test_fetch_read();
    do_reset();
    bus.if_req = 1; bus.if_addr = 24'd4;
    @(negedge clk);
    n_cmp++; if (bus.if_gnt !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt: got %b want 1", bus.if_gnt); end
    n_cmp++; if (bus.d_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_dgnt: got %b want 0", bus.d_gnt); end
    bus.if_req = 0; bus.if_addr = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.mem_addr !== 24'd4 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_bus: got addr %h we %b want 4/0", bus.mem_addr, bus.mem_we); end
      n_cmp++; if (bus.if_gnt !== 1'b0 || bus.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_quiet: got gnt %b rvalid %b want 0/0", bus.if_gnt, bus.if_rvalid); end
      if (k == 4) begin bus.mem_op_r = 1; bus.mem_rdata = 32'hf0f0f0f0; end
    end
    @(negedge clk);
    bus.mem_op_r = 0; bus.mem_rdata = '0;
    n_cmp++; if (bus.if_rvalid !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid: got %b want 1", bus.if_rvalid); end
    n_cmp++; if (bus.if_rdata !== 32'hf0f0f0f0) begin n_fail++; $display("FAIL fetch_rdata: got %h want f0f0f0f0", bus.if_rdata); end
    n_cmp++; if (bus.d_rvalid !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL fetch_side: got d_rvalid %b err %b want 0/0", bus.d_rvalid, bus.err); end
    @(negedge clk);
    n_cmp++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'hf0f0f0f0) begin n_fail++; $display("FAIL fetch_hold: got rvalid %b rdata %h want 0/f0f0f0f0", bus.if_rvalid, bus.if_rdata); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.if_req = 1; bus.if_addr = 24'd8;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 24'd4; bus.d_wdata = 32'h12345678;
    @(negedge clk);
    n_cmp++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin n_fail++; $display("FAIL sim_first: got if_gnt %b d_gnt %b want 1/0", bus.if_gnt, bus.d_gnt); end
    n_cmp++; if (bus.mem_addr !== 24'd8 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL sim_first_bus: got addr %h we %b want 8/0", bus.mem_addr, bus.mem_we); end
    bus.if_req = 0; bus.mem_op_r = 1; bus.mem_rdata = 32'haaaa5555;
    @(negedge clk);
    bus.mem_op_r = 0;
    n_cmp++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'haaaa5555) begin n_fail++; $display("FAIL sim_if_resp: got %b %h want 1 aaaa5555", bus.if_rvalid, bus.if_rdata); end
    @(negedge clk);
    n_cmp++; if (bus.d_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL sim_idle_gap: got d_gnt %b we %b want 0/0", bus.d_gnt, bus.mem_we); end
    @(negedge clk);
    n_cmp++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL sim_dgnt: got %b want 1", bus.d_gnt); end
    n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h12345678 || bus.mem_addr !== 24'd4) begin n_fail++; $display("FAIL sim_wbus: got we %b data %h addr %h want 1/12345678/4", bus.mem_we, bus.mem_wdata, bus.mem_addr); end
    bus.d_req = 0;
    @(negedge clk);
    n_cmp++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL sim_we_hold: got %b want 1", bus.mem_we); end
    bus.mem_op_r = 1; bus.mem_rdata = 32'hdeadbeef;
    @(negedge clk);
    bus.mem_op_r = 0;
    n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL sim_wack: got rvalid %b rdata %h want 1/0", bus.d_rvalid, bus.d_rdata); end
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL sim_resp_we: got we %b err %b want 0/0", bus.mem_we, bus.err); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ngnt = 0;
    int last_c = -1;
    req_id_t who, want;
    do_reset();
    bus.if_req = 1; bus.if_addr = 24'd12;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 24'd20;
    for (int c = 1; c <= 40 && ngnt < 4; c++) begin
      @(negedge clk);
      bus.mem_op_r = 0;
      n_cmp++; if ((bus.if_gnt & bus.d_gnt) !== 1'b0) begin n_fail++; $display("FAIL b2b_both_gnt: got 1 want 0 at cycle %0d", c); end
      if (bus.if_gnt || bus.d_gnt) begin
        who  = bus.d_gnt ? REQ_D : REQ_IF;
        want = (ngnt % 2 == 0) ? REQ_IF : REQ_D;
        n_cmp++; if (who !== want) begin n_fail++; $display("FAIL b2b_order: got %0d want %0d at grant %0d", who, want, ngnt); end
        if (last_c >= 0) begin
          n_cmp++; if (c - last_c !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 3", c - last_c); end
        end
        last_c = c;
        ngnt++;
        bus.mem_op_r = 1; bus.mem_rdata = $urandom;
        if (ngnt == 4) begin bus.if_req = 0; bus.d_req = 0; end
      end
    end
    n_cmp++; if (ngnt !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", ngnt); end
    @(negedge clk);
    bus.mem_op_r = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int seen = -1;
    do_reset();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 24'd3;
    @(negedge clk);
    bus.d_req = 0; bus.mem_op_r = 1; bus.mem_rdata = 32'h5a5a5a5a;
    @(negedge clk);
    bus.mem_op_r = 0;
    n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h5a5a5a5a) begin n_fail++; $display("FAIL to_prime: got %b %h want 1 5a5a5a5a", bus.d_rvalid, bus.d_rdata); end
    @(negedge clk);
    bus.d_req = 1; bus.d_addr = 24'd7;
    @(negedge clk);
    n_cmp++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL to_gnt: got %b want 1", bus.d_gnt); end
    bus.d_req = 0;
    for (int k = 1; k <= 30 && seen < 0; k++) begin
      @(negedge clk);
      if (bus.err || bus.d_rvalid) seen = k;
    end
    n_cmp++; if (seen !== 16) begin n_fail++; $display("FAIL to_latency: got %0d want 16", seen); end
    n_cmp++; if (bus.err !== 1'b1 || bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL to_resp: got err %b rvalid %b rdata %h want 1/1/0", bus.err, bus.d_rvalid, bus.d_rdata); end
    @(negedge clk);
    n_cmp++; if (bus.err !== 1'b0 || bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got err %b rvalid %b want 0/0", bus.err, bus.d_rvalid); end
    bus.if_req = 1; bus.if_addr = 24'd9;
    @(negedge clk);
    n_cmp++; if (bus.if_gnt !== 1'b1) begin n_fail++; $display("FAIL to_back_idle: got %b want 1", bus.if_gnt); end
    bus.if_req = 0; bus.mem_op_r = 1;
    @(negedge clk);
    bus.mem_op_r = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 24'h55; bus.d_wdata = 32'hcafef00d;
    @(negedge clk);
    bus.d_req = 0;
    @(negedge clk);
    n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 24'h55) begin n_fail++; $display("FAIL rm_pre: got we %b addr %h want 1/55", bus.mem_we, bus.mem_addr); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (any_out() !== 1'b0) begin n_fail++; $display("FAIL rm_async: got %b want 0", any_out()); end
    @(negedge clk);
    bus.mem_op_r = 1; bus.mem_rdata = 32'h77777777;
    @(negedge clk);
    n_cmp++; if (any_out() !== 1'b0) begin n_fail++; $display("FAIL rm_held: got %b want 0", any_out()); end
    bus.mem_op_r = 0;
    rst_n = 1;
    bus.if_req = 1; bus.if_addr = 24'd1;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 24'd2;
    @(negedge clk);
    n_cmp++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin n_fail++; $display("FAIL rm_tie: got if %b d %b want 1/0", bus.if_gnt, bus.d_gnt); end
    n_cmp++; if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_no_rvalid: got d %b if %b want 0/0", bus.d_rvalid, bus.if_rvalid); end
    bus.if_req = 0; bus.d_req = 0; bus.mem_op_r = 1; bus.mem_rdata = 32'h0badcafe;
    @(negedge clk);
    bus.mem_op_r = 0;
    n_cmp++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0badcafe) begin n_fail++; $display("FAIL rm_after: got %b %h want 1 0badcafe", bus.if_rvalid, bus.if_rdata); end
    @(negedge clk);
  endtask

  task automatic test_spurious();
    do_reset();
    bus.mem_op_r = 1; bus.mem_rdata = 32'h11111111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 1) bus.mem_op_r = 0;
      n_cmp++; if ({bus.if_rvalid, bus.d_rvalid, bus.err} !== 3'b000) begin n_fail++; $display("FAIL spur_quiet: got %b want 000", {bus.if_rvalid, bus.d_rvalid, bus.err}); end
    end
    bus.if_req = 1; bus.if_addr = 24'd16;
    @(negedge clk);
    n_cmp++; if (bus.if_gnt !== 1'b1) begin n_fail++; $display("FAIL spur_gnt: got %b want 1", bus.if_gnt); end
    bus.if_req = 0;
    @(negedge clk);
    @(negedge clk);
    bus.mem_op_r = 1; bus.mem_rdata = 32'h13572468;
    @(negedge clk);
    bus.mem_op_r = 0;
    n_cmp++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h13572468 || bus.err !== 1'b0) begin n_fail++; $display("FAIL spur_resp: got %b %h err %b want 1 13572468 0", bus.if_rvalid, bus.if_rdata, bus.err); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [DW-1:0] mem_m [16];
    logic [DW-1:0] exp_if_rd, exp_d_rd, exp_rd;
    logic [AW-1:0] if_a, d_a, e_addr;
    logic [DW-1:0] d_wd, e_wd;
    logic          d_w, e_we;
    bit            if_pend, if_wait, d_pend, d_wait, busy, in_busy;
    req_id_t       last_g, own;
    int            gnt_due, op_cyc, resp_due, idle_from, ndone;
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    do_reset();
    exp_if_rd = '0; exp_d_rd = '0; exp_rd = '0; last_g = REQ_D; own = REQ_IF;
    if_a = '0; d_a = '0; d_wd = '0; d_w = 0; e_addr = '0; e_wd = '0; e_we = 0;
    if_pend = 0; if_wait = 0; d_pend = 0; d_wait = 0; busy = 0;
    gnt_due = -1; op_cyc = -1; resp_due = -1; idle_from = 0; ndone = 0;
    for (int c = 0; c < 800; c++) begin
      if (c > 0) @(negedge clk);
      n_cmp++; if (bus.if_gnt !== (c == gnt_due && own == REQ_IF)) begin n_fail++; $display("FAIL rnd_if_gnt: got %b at cycle %0d", bus.if_gnt, c); end
      n_cmp++; if (bus.d_gnt !== (c == gnt_due && own == REQ_D)) begin n_fail++; $display("FAIL rnd_d_gnt: got %b at cycle %0d", bus.d_gnt, c); end
      n_cmp++; if (bus.if_rvalid !== (c == resp_due && own == REQ_IF)) begin n_fail++; $display("FAIL rnd_if_rvalid: got %b at cycle %0d", bus.if_rvalid, c); end
      n_cmp++; if (bus.d_rvalid !== (c == resp_due && own == REQ_D)) begin n_fail++; $display("FAIL rnd_d_rvalid: got %b at cycle %0d", bus.d_rvalid, c); end
      n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rnd_err: got %b want 0 at cycle %0d", bus.err, c); end
      if (c == resp_due) begin
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rnd_resp_we: got %b want 0", bus.mem_we); end
        if (own == REQ_IF) begin exp_if_rd = exp_rd; if_wait = 0; end
        else begin if (!e_we) exp_d_rd = exp_rd; d_wait = 0; end
        ndone++; busy = 0; gnt_due = -1; op_cyc = -1;
      end
      n_cmp++; if (bus.if_rdata !== exp_if_rd) begin n_fail++; $display("FAIL rnd_if_rdata: got %h want %h at cycle %0d", bus.if_rdata, exp_if_rd, c); end
      n_cmp++; if (bus.d_rdata !== exp_d_rd) begin n_fail++; $display("FAIL rnd_d_rdata: got %h want %h at cycle %0d", bus.d_rdata, exp_d_rd, c); end
      in_busy = (gnt_due >= 0 && c >= gnt_due && (op_cyc < 0 || c <= op_cyc));
      if (in_busy) begin
        n_cmp++; if (bus.mem_addr !== e_addr || bus.mem_we !== e_we) begin n_fail++; $display("FAIL rnd_mem_bus: got %h/%b want %h/%b at cycle %0d", bus.mem_addr, bus.mem_we, e_addr, e_we, c); end
        if (e_we) begin
          n_cmp++; if (bus.mem_wdata !== e_wd) begin n_fail++; $display("FAIL rnd_mem_wdata: got %h want %h", bus.mem_wdata, e_wd); end
        end
      end
      // Drive the memory controller and requesters for this cycle.
      bus.mem_op_r = 0; bus.mem_rdata = $urandom;
      if (c == gnt_due) begin
        if (own == REQ_IF) begin bus.if_req = 0; if_pend = 0; if_wait = 1; end
        else begin bus.d_req = 0; d_pend = 0; d_wait = 1; end
        op_cyc = c + $urandom_range(0, 5);
      end
      if (c == op_cyc) begin
        bus.mem_op_r = 1;
        if (e_we) mem_m[e_addr[3:0]] = e_wd;
        else begin exp_rd = mem_m[e_addr[3:0]]; bus.mem_rdata = exp_rd; end
        resp_due = c + 1; idle_from = c + 2;
      end else if (!(gnt_due >= 0 && c >= gnt_due) && $urandom_range(0, 3) == 0) begin
        bus.mem_op_r = 1;
      end
      if (!if_pend && !if_wait && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_a = AW'($urandom_range(0, 15));
        bus.if_req = 1; bus.if_addr = if_a;
      end
      if (!d_pend && !d_wait && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_a = AW'($urandom_range(0, 15)); d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
        bus.d_req = 1; bus.d_addr = d_a; bus.d_we = d_w; bus.d_wdata = d_wd;
      end
      if (!busy && c >= idle_from && (if_pend || d_pend)) begin
        if (if_pend && d_pend) own = (last_g == REQ_D) ? REQ_IF : REQ_D;
        else own = d_pend ? REQ_D : REQ_IF;
        if (own == REQ_D) begin e_addr = d_a; e_we = d_w; e_wd = d_wd; end
        else begin e_addr = if_a; e_we = 0; e_wd = '0; end
        last_g = own; busy = 1; gnt_due = c + 1;
      end
    end
    n_cmp++; if (ndone < 30) begin n_fail++; $display("FAIL rnd_txn_count: got %0d want >= 30", ndone); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1;
    idle_inputs();
    #1 rst_n = 0;
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
